// File: rtl/mmc_sort_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : mmc_sort_pkg
//  Purpose  : Shared sizes, FSM state type and fp32 field positions for the
//             MMC capacitor-voltage sort scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package mmc_sort_pkg;

    localparam int N_CELLS = 12;
    localparam int FP_W    = 32;

    localparam int c_fp_sign_bit = 31;
    localparam int c_fp_exp_msb  = 30;
    localparam int c_fp_exp_lsb  = 23;
    localparam int c_fp_man_msb  = 22;
    localparam int c_fp_man_lsb  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } sort_state_t;

endpackage
`default_nettype wire

// File: rtl/mmc_sort_scheduler_fp32_lt.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_lt
//  Purpose  : Combinational a < b on IEEE-754 single precision words using
//             sign-magnitude ordering; +0 and -0 compare equal.
//  Revision : 1.0 - initial release
// ============================================================================
module fp32_lt
    import mmc_sort_pkg::*;
(
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic            o_lt
);

    logic        w_sa;
    logic        w_sb;
    logic [30:0] w_ma;
    logic [30:0] w_mb;

    always_comb begin
        w_sa = i_a[c_fp_sign_bit];
        w_sb = i_b[c_fp_sign_bit];
        w_ma = {i_a[c_fp_exp_msb:c_fp_exp_lsb], i_a[c_fp_man_msb:c_fp_man_lsb]};
        w_mb = {i_b[c_fp_exp_msb:c_fp_exp_lsb], i_b[c_fp_man_msb:c_fp_man_lsb]};
        o_lt = 1'b0;
        if ((w_ma == '0) && (w_mb == '0)) begin
            o_lt = 1'b0;
        end else if (w_sa != w_sb) begin
            o_lt = w_sa;
        end else if (!w_sa) begin
            o_lt = (w_ma < w_mb);
        end else begin
            // Both negative: larger magnitude is the smaller value
            o_lt = (w_ma > w_mb);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmc_sort_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : mmc_sort_scheduler
//  Purpose  : Selection-sort scheduler choosing which n of 12 MMC submodules to
//             insert, using one shared fp32 comparator. Optional abort input
//             enabled by defining MMC_SORT_ABORT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mmc_sort_scheduler
    import mmc_sort_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
`ifdef MMC_SORT_ABORT_EN
    input  logic                    abort,
`endif
    input  logic [N_CELLS*FP_W-1:0] V,
    input  logic [FP_W-1:0]         I,
    input  logic [2:0]              n,
    output logic [N_CELLS:1]        M,
    output logic                    busy,
    output logic                    done
);

    sort_state_t                     r_state;
    sort_state_t                     w_next_state;
    logic [N_CELLS-1:0][FP_W-1:0]    r_v;
    logic                            r_dir;
    logic [2:0]                      r_n;
    logic [2:0]                      r_count;
    logic [N_CELLS-1:0]              r_mask;
    logic [3:0]                      r_idx;
    logic [3:0]                      r_best;
    logic                            r_best_vld;

    logic [FP_W-1:0]                 w_cand;
    logic [FP_W-1:0]                 w_best_v;
    logic [FP_W-1:0]                 w_op_a;
    logic [FP_W-1:0]                 w_op_b;
    logic                            w_better;
    logic                            w_take;
    logic                            w_last_idx;
    logic [2:0]                      w_count_inc;
    logic                            w_pass_done;
    logic                            w_abort;
    logic                            w_unused;

`ifdef MMC_SORT_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Only the sign of the arm current matters
    assign w_unused = ^I[FP_W-2:0];

    // dir=1 swaps operands so the same a<b unit answers "candidate > best"
    assign w_cand   = r_v[r_idx];
    assign w_best_v = r_v[r_best];
    assign w_op_a   = r_dir ? w_best_v : w_cand;
    assign w_op_b   = r_dir ? w_cand   : w_best_v;

    fp32_lt u_fp32_lt (
        .i_a  (w_op_a),
        .i_b  (w_op_b),
        .o_lt (w_better)
    );

    assign w_take      = !r_mask[r_idx] && (!r_best_vld || w_better);
    assign w_last_idx  = (r_idx == 4'(N_CELLS - 1));
    assign w_count_inc = r_count + 3'd1;
    assign w_pass_done = (w_count_inc == r_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (n == 3'd0) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_last_idx) begin
                    w_next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = w_pass_done ? ST_DONE : ST_SCAN;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v        <= '0;
            r_dir      <= 1'b0;
            r_n        <= 3'd0;
            r_count    <= 3'd0;
            r_mask     <= '0;
            r_idx      <= 4'd0;
            r_best     <= 4'd0;
            r_best_vld <= 1'b0;
            M          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_v        <= V;
                        r_dir      <= I[c_fp_sign_bit];
                        r_n        <= n;
                        r_count    <= 3'd0;
                        r_mask     <= '0;
                        r_idx      <= 4'd0;
                        r_best_vld <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_abort) begin
                        busy <= 1'b0;
                    end else begin
                        if (w_take) begin
                            r_best     <= r_idx;
                            r_best_vld <= 1'b1;
                        end
                        r_idx <= w_last_idx ? 4'd0 : r_idx + 4'd1;
                    end
                end
                ST_COMMIT: begin
                    if (w_abort) begin
                        busy <= 1'b0;
                    end else begin
                        r_mask[r_best] <= 1'b1;
                        r_count        <= w_count_inc;
                        r_idx          <= 4'd0;
                        r_best_vld     <= 1'b0;
                    end
                end
                ST_DONE: begin
                    M    <= r_mask;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmc_sort_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmc_sort_scheduler
//  Purpose  : Directed self-checking bench for mmc_sort_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmc_sort_scheduler;
    import mmc_sort_pkg::*;

    logic                    clk   = 1'b0;
    logic                    rst   = 1'b1;
    logic                    start = 1'b0;
`ifdef MMC_SORT_ABORT_EN
    logic                    abort = 1'b0;
`endif
    logic [N_CELLS*FP_W-1:0] V     = '0;
    logic [FP_W-1:0]         I     = '0;
    logic [2:0]              n     = '0;
    logic [N_CELLS:1]        M;
    logic                    busy;
    logic                    done;

    int num_asserts = 0;
    int num_fails   = 0;

    logic [FP_W-1:0] ramp [N_CELLS] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000
    };
    logic [FP_W-1:0] flat5 [N_CELLS];
    logic [FP_W-1:0] zeros [N_CELLS];

    mmc_sort_scheduler dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef MMC_SORT_ABORT_EN
        .abort (abort),
`endif
        .V     (V),
        .I     (I),
        .n     (n),
        .M     (M),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        num_asserts++;
        if (act !== exp) begin
            num_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [N_CELLS*FP_W-1:0] pack_v(input logic [FP_W-1:0] a [N_CELLS]);
        logic [N_CELLS*FP_W-1:0] r;
        for (int k = 0; k < N_CELLS; k++) r[k*FP_W +: FP_W] = a[k];
        return r;
    endfunction

    // One sort: inputs are scrambled after acceptance; optionally re-pulse start mid-sort
    task automatic run_sort(input string tag, input logic [N_CELLS*FP_W-1:0] v,
                            input logic [FP_W-1:0] cur, input logic [2:0] cnt,
                            input logic [11:0] exp_m, input int inject_at);
        int first_done;
        int pulses;
        int window;
        first_done = -1;
        pulses     = 0;
        window     = 13 * int'(cnt) + 4;
        V = v; I = cur; n = cnt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; V = ~v; I = ~cur; n = ~cnt;
        check_eq({tag, "_busy_accept"}, 32'(busy), 32'd1);
        for (int c = 1; c <= window; c++) begin
            start = (c == inject_at);
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (first_done < 0) first_done = c;
            end
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 32'(first_done), 32'(13 * int'(cnt) + 1));
        check_eq({tag, "_done_pulses"}, 32'(pulses), 32'd1);
        check_eq({tag, "_mask"}, 32'(M), 32'(exp_m));
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FP_W-1:0] mix [N_CELLS];
        for (int k = 0; k < N_CELLS; k++) begin
            flat5[k] = 32'h40A00000;
            zeros[k] = 32'h3F800000;
            mix[k]   = 32'h3F800000;
        end
        mix[0] = 32'h80000000;
        mix[1] = 32'h00000000;
        mix[2] = 32'hC0000000;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_M", 32'(M), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_sort("discharge_n3", pack_v(ramp), 32'hC1B80000, 3'd3, 12'hE00, 0);
        run_sort("charge_n3",    pack_v(ramp), 32'h31B80000, 3'd3, 12'h007, 0);
        run_sort("tie_n2",       pack_v(flat5), 32'h31B80000, 3'd2, 12'h003, 0);
        run_sort("zeros_n2",     pack_v(mix), 32'h31B80000, 3'd2, 12'h005, 0);
        run_sort("n0",           pack_v(ramp), 32'h31B80000, 3'd0, 12'h000, 0);
        run_sort("restart_n7",   pack_v(ramp), 32'h31B80000, 3'd7, 12'h07F, 20);

        // Reset during the second SCAN pass
        V = pack_v(ramp); I = 32'hC1B80000; n = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check_eq("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst_M", 32'(M), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_sort("after_rst", pack_v(ramp), 32'hC1B80000, 3'd3, 12'hE00, 0);

`ifdef MMC_SORT_ABORT_EN
        begin
            int pulses;
            pulses = 0;
            V = pack_v(ramp); I = 32'h31B80000; n = 3'd3; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check_eq("abort_busy", 32'(busy), 32'd0);
            for (int c = 0; c < 50; c++) begin
                @(posedge clk); #1;
                if (done) pulses++;
            end
            check_eq("abort_no_done", 32'(pulses), 32'd0);
            check_eq("abort_M_kept", 32'(M), 32'hE00);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fails);
        $finish;
    end

endmodule
`default_nettype wire
